// File: rtl/psm_phase_gen_pkg.sv
// rtl/psm_phase_gen_pkg.sv - shared constants and FSM encoding for the phase-shift carrier
package psm_phase_gen_pkg;
  localparam int BITS_DATA_DEF = 16;
  localparam int BITS_DT_DEF   = 8;
  localparam int HP_MIN        = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } psm_state_t;
endpackage

// File: rtl/psm_leg_cmp.sv
// rtl/psm_leg_cmp.sv - registered leg comparator: high while the offset position is in the first half-period
module psm_leg_cmp #(
  parameter int BITS_DATA = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [BITS_DATA:0]   cnt,
  input  logic [BITS_DATA-1:0] hp,
  input  logic [BITS_DATA-1:0] ofs,
  output logic                 leg
);
  logic [BITS_DATA:0] hp_w, ofs_w, per, pb;

  // When cnt + per overflows, the modular wrap still yields the correct position.
  always_comb begin
    hp_w  = {1'b0, hp};
    ofs_w = {1'b0, ofs};
    per   = hp_w << 1;
    pb    = (cnt >= ofs_w) ? (cnt - ofs_w) : (cnt + per - ofs_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leg <= 1'b0;
    end else begin
      leg <= en && (pb < hp_w);
    end
  end
endmodule

// File: rtl/psm_phase_gen.sv
// rtl/psm_phase_gen.sv - two-leg phase-shifted square wave generator with period-boundary shadow loads
module psm_phase_gen
  import psm_phase_gen_pkg::*;
#(
  parameter int BITS_DATA = BITS_DATA_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 iEN,
  input  logic [BITS_DATA-1:0] iFREQUENCY,
  input  logic [BITS_DATA-1:0] iPHASE,
  output logic                 oPSM_A,
  output logic                 oPSM_B,
  output logic                 oSYNC
);
  localparam logic [BITS_DATA-1:0] HP_MIN_W = BITS_DATA'(HP_MIN);
  localparam logic [BITS_DATA:0]   CNT_ONE  = (BITS_DATA+1)'(1);

  psm_state_t           state, state_nx;
  logic [BITS_DATA:0]   cnt, cnt_nx, per;
  logic [BITS_DATA-1:0] hp_s, ph_s, hp_ld, ph_ld;
  logic                 load, run, wrap;

  always_comb begin
    hp_ld    = (iFREQUENCY < HP_MIN_W) ? HP_MIN_W : iFREQUENCY;
    ph_ld    = (iPHASE > hp_ld) ? hp_ld : iPHASE;
    per      = {1'b0, hp_s} << 1;
    wrap     = (cnt == per - CNT_ONE);
    run      = (state == RUN) && iEN;
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (iEN) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        // Dropping enable aborts the period outright; no completion is waited for.
        if (!iEN) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (wrap) begin
          cnt_nx = '0;
          load   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      hp_s  <= HP_MIN_W;
      ph_s  <= '0;
      oSYNC <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      oSYNC <= run && (cnt == '0);
      if (load) begin
        hp_s <= hp_ld;
        ph_s <= ph_ld;
      end
    end
  end

  psm_leg_cmp #(.BITS_DATA(BITS_DATA)) u_leg_a (
    .clk   (CLK),
    .rst_n (RST),
    .en    (run),
    .cnt   (cnt),
    .hp    (hp_s),
    .ofs   ('0),
    .leg   (oPSM_A)
  );

  psm_leg_cmp #(.BITS_DATA(BITS_DATA)) u_leg_b (
    .clk   (CLK),
    .rst_n (RST),
    .en    (run),
    .cnt   (cnt),
    .hp    (hp_s),
    .ofs   (ph_s),
    .leg   (oPSM_B)
  );
endmodule

// File: tb/tb_psm_phase_gen.sv
// tb/tb_psm_phase_gen.sv - directed self-checking bench for psm_phase_gen with a deadtime stage on leg A
module tb_psm_phase_gen;
  import psm_phase_gen_pkg::*;

  localparam int BD = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          iEN = 1'b0;
  logic [BD-1:0] iFREQUENCY = '0;
  logic [BD-1:0] iPHASE = '0;
  logic          oPSM_A, oPSM_B, oSYNC;

  int vectors = 0;
  int miscompares = 0;

  logic                   dt_rst, gh, gl, dt_last, a1, a2;
  logic [BITS_DT_DEF-1:0] dcnt;
  localparam logic [BITS_DT_DEF-1:0] DT = 1;

  always #5 CLK = ~CLK;

  psm_phase_gen #(.BITS_DATA(BD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iEN        (iEN),
    .iFREQUENCY (iFREQUENCY),
    .iPHASE     (iPHASE),
    .oPSM_A     (oPSM_A),
    .oPSM_B     (oPSM_B),
    .oSYNC      (oSYNC)
  );

  // Downstream deadtime stage: active-high reset, complementary gates, DT idle cycles per edge.
  assign dt_rst = ~RST;
  always @(posedge CLK or posedge dt_rst) begin
    if (dt_rst) begin
      gh <= 1'b0; gl <= 1'b0; dt_last <= 1'b0; dcnt <= '0;
    end else if (oPSM_A != dt_last) begin
      dt_last <= oPSM_A; gh <= 1'b0; gl <= 1'b0; dcnt <= DT - 1'b1;
    end else if (dcnt != '0) begin
      dcnt <= dcnt - 1'b1;
    end else begin
      gh <= dt_last; gl <= ~dt_last;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_per(input string tag, input int hp, input int ph, input int n,
                         input int start, input bit dt);
    int   c;
    logic ea, eb, es;
    for (int i = 0; i < n; i++) begin
      c  = (start + i) % (2 * hp);
      ea = (c < hp);
      eb = (((c - ph + 2 * hp) % (2 * hp)) < hp);
      es = (c == 0);
      chk({tag, "_a"}, {7'd0, oPSM_A}, {7'd0, ea});
      chk({tag, "_b"}, {7'd0, oPSM_B}, {7'd0, eb});
      chk({tag, "_sync"}, {7'd0, oSYNC}, {7'd0, es});
      if (dt) begin
        chk({tag, "_gates"}, {6'd0, gh, gl}, (a1 != a2) ? 8'd0 : {6'd0, a1, ~a1});
        a2 = a1;
        a1 = oPSM_A;
      end
      tick();
    end
  endtask

  initial begin
    int f, p, hp, phe;
    a1 = 1'b0;
    a2 = 1'b0;
    tick(); tick(); tick();
    chk("reset_a", {7'd0, oPSM_A}, 8'd0);
    chk("reset_b", {7'd0, oPSM_B}, 8'd0);
    chk("reset_sync", {7'd0, oSYNC}, 8'd0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_a", {7'd0, oPSM_A}, 8'd0);
    end

    iFREQUENCY = 20; iPHASE = 0; iEN = 1'b1;
    tick();
    chk("start_a", {7'd0, oPSM_A}, 8'd0);
    chk("start_sync", {7'd0, oSYNC}, 8'd0);
    tick();
    run_per("basic", 20, 0, 80, 0, 1'b0);

    iPHASE = 5;
    run_per("keep0", 20, 0, 40, 0, 1'b0);
    run_per("phase5", 20, 5, 80, 0, 1'b0);

    iPHASE = 30;
    run_per("keep5", 20, 5, 40, 0, 1'b0);
    run_per("sat", 20, 20, 80, 0, 1'b0);

    iFREQUENCY = 1; iPHASE = 0;
    run_per("keepsat", 20, 20, 40, 0, 1'b0);
    run_per("clamp", 2, 0, 12, 0, 1'b0);

    iFREQUENCY = 20;
    run_per("keepclamp", 2, 0, 4, 0, 1'b0);
    run_per("pre_mid", 20, 0, 7, 0, 1'b0);
    iFREQUENCY = 10; iPHASE = 3;
    run_per("mid_old", 20, 0, 33, 7, 1'b0);
    run_per("mid_new", 10, 3, 40, 0, 1'b0);

    run_per("pre_abort", 10, 3, 5, 0, 1'b0);
    iEN = 1'b0;
    tick();
    chk("abort_a", {7'd0, oPSM_A}, 8'd0);
    chk("abort_b", {7'd0, oPSM_B}, 8'd0);
    chk("abort_sync", {7'd0, oSYNC}, 8'd0);
    tick();
    chk("abort_idle_a", {7'd0, oPSM_A}, 8'd0);
    iEN = 1'b1;
    tick();
    chk("reen_start_sync", {7'd0, oSYNC}, 8'd0);
    tick();
    run_per("reen", 10, 3, 20, 0, 1'b0);

    RST = 1'b0;
    #2;
    chk("rst_async_a", {7'd0, oPSM_A}, 8'd0);
    chk("rst_async_b", {7'd0, oPSM_B}, 8'd0);
    chk("rst_async_sync", {7'd0, oSYNC}, 8'd0);
    iEN = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_a", {7'd0, oPSM_A}, 8'd0);
      chk("post_rst_sync", {7'd0, oSYNC}, 8'd0);
    end

    for (int k = 0; k < 100; k++) begin
      iEN = 1'b0;
      tick();
      f = $urandom_range(1, 12);
      p = $urandom_range(0, 15);
      iFREQUENCY = f[BD-1:0];
      iPHASE = p[BD-1:0];
      iEN = 1'b1;
      tick();
      tick();
      hp  = (f < 2) ? 2 : f;
      phe = (p > hp) ? hp : p;
      a1 = 1'b0;
      a2 = 1'b0;
      run_per("rnd", hp, phe, 2 * hp, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
